regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: WIDTH, 32, data word width in bits.
REQ-002 Parameter: NREG, 32, number of registers; address width is fixed at 5 bits.
REQ-003 Port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port: ra1  input  5  read address, port 1 (source operand rs, feeds ALU input a).
REQ-006 Port: ra2  input  5  read address, port 2 (source operand rt, feeds ALU input b).
REQ-007 Port: rd1  output  WIDTH  read data, port 1.
REQ-008 Port: rd2  output  WIDTH  read data, port 2.
REQ-009 Port: we3  input  1  write enable, port 3.
REQ-010 Port: wa3  input  5  write address, port 3 (destination rd/rt).
REQ-011 Port: wd3  input  WIDTH  write data, port 3 (ALU result x or load data).

Function
REQ-012 Storage SHALL be NREG registers of WIDTH bits, indexed 0..31.
REQ-013 Register 0 SHALL always read as 0; writes to address 0 SHALL be discarded with no side effect.
REQ-014 Reads SHALL be combinational: rd1 = reg[ra1] and rd2 = reg[ra2] within the same cycle; there are no read-enable ports.
REQ-015 A write SHALL occur on the rising edge of clk when we3=1, rst=0 and wa3!=0: reg[wa3] <= wd3.
REQ-016 With we3=0, all register contents SHALL hold.
REQ-017 Both read ports SHALL address the same register independently; ra1==ra2 SHALL return identical data on both ports.
REQ-018 A write to register N SHALL change no register other than N.
REQ-019 Write-read collision (we3=1, wa3==raX, wa3!=0, same cycle): the result SHALL follow REQ-027/REQ-028.
REQ-020 There SHALL be no X propagation from storage: every register holds a defined value after the first reset.
REQ-021 Write latency SHALL be 1 cycle: data written at edge k SHALL appear on a matching read port after edge k, with no further delay.

Reset
REQ-022 When rst=1 at a rising edge of clk, all NREG registers SHALL be cleared to 0 on that edge.
REQ-023 While rst=1, a simultaneous write (we3=1) SHALL be ignored; reset has priority.
REQ-024 After the reset edge, rd1 and rd2 SHALL be 0 for every address until the first write.
REQ-025 rst asserted mid-operation SHALL discard all prior contents; no partial state is retained.
REQ-026 rst SHALL have no asynchronous effect: between clock edges, storage and outputs do not change because of rst.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined: when we3=1, rst=0, wa3!=0 and wa3==raX, rdX SHALL equal wd3 combinationally in the same cycle (write-through forwarding).
REQ-028 With REGFILE_BYPASS_EN undefined: in the collision case, rdX SHALL return the old reg[raX] until the write edge, then the new value.
REQ-029 With either setting, forwarding SHALL never apply to address 0 and SHALL be suppressed while rst=1.

Verification
REQ-030 Reset: apply rst=1 for one edge after writing 0xDEADBEEF to r5 -> r5 and all other registers read 0x00000000.
REQ-031 Basic write/read: write r7=0x12345678 and r8=0xFFFFFFFF; set ra1=7, ra2=8 -> rd1=0x12345678 and rd2=0xFFFFFFFF; r6 is unchanged at 0.
REQ-032 r0: write wa3=0, wd3=0xA5A5A5A5 with we3=1 -> rd1 with ra1=0 returns 0x00000000 both before and after the edge.
REQ-033 Collision: r3=0x11 initially; drive we3=1, wa3=3, wd3=0x22 and ra1=ra2=3 in the same cycle -> with REGFILE_BYPASS_EN, rd1=rd2=0x22 before the edge; without it, rd1=rd2=0x11 before the edge and 0x22 after.
REQ-034 Reset priority: rst=1, we3=1, wa3=9, wd3=0x55 on the same edge -> r9 reads 0x00000000 afterwards.
REQ-035 Hold/sweep: write each r1..r31 with value 0x100+N, then hold we3=0 for 10 cycles -> every rN reads 0x100+N on both ports.

Source files
------------

// File: rtl/regfile_if.sv
// Register-file access bus: two combinational read ports and one write port.
// The master (datapath/testbench) drives addresses and write data; the
// slave (regfile) returns read data.
interface regfile_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             we3;
    logic [4:0]       wa3;
    logic [WIDTH-1:0] wd3;

    modport master (
        output ra1, ra2, we3, wa3, wd3,
        input  rd1, rd2
    );

    modport slave (
        input  ra1, ra2, we3, wa3, wd3,
        output rd1, rd2
    );
endinterface

// File: rtl/regfile.sv
// regfile: NREG x WIDTH register file with two combinational read ports and
// one synchronous write port. Register 0 is hard-wired to zero.
// Reset is synchronous and active-high and clears every register.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write that
// targets a register currently being read is forwarded to the read port in
// the same cycle (write-through). When undefined, reads return the stored
// value until the write edge.
module regfile #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  rf
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             wr_en_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    // Fetch one stored word; address 0 and out-of-range addresses read zero.
    function automatic logic [WIDTH-1:0] stored_word(
        input logic [WIDTH-1:0] regs [NREG],
        input logic [4:0]       ra
    );
        logic [WIDTH-1:0] val;
        if ((ra != 5'd0) && (int'(ra) < NREG)) begin
            val = regs[ra];
        end else begin
            val = {WIDTH{1'b0}};
        end
        return val;
    endfunction

    // Qualify the write: reset wins, and address 0 / unimplemented addresses are dropped.
    always_comb begin
        wr_en_s = 1'b0;
        if (rf.we3 && !rst && (rf.wa3 != 5'd0) && (int'(rf.wa3) < NREG)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next storage contents: clear on reset, otherwise update only the addressed register.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (rst) begin
                regs_d[i] = {WIDTH{1'b0}};
            end else if (i == 0) begin
                regs_d[i] = {WIDTH{1'b0}};
            end else if (wr_en_s && (int'(rf.wa3) == i)) begin
                regs_d[i] = rf.wd3;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Storage flops; all updates, including reset, happen on the rising edge.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Read ports: stored value, optionally overridden by an in-flight write.
    always_comb begin
        rd1_s = stored_word(regs_q, rf.ra1);
        rd2_s = stored_word(regs_q, rf.ra2);
`ifdef REGFILE_BYPASS_EN
        // wr_en_s already excludes reset and address 0, so forwarding never hits r0.
        if (wr_en_s && (rf.wa3 == rf.ra1)) begin
            rd1_s = rf.wd3;
        end else begin
            rd1_s = stored_word(regs_q, rf.ra1);
        end
        if (wr_en_s && (rf.wa3 == rf.ra2)) begin
            rd2_s = rf.wd3;
        end else begin
            rd2_s = stored_word(regs_q, rf.ra2);
        end
`else
        rd1_s = stored_word(regs_q, rf.ra1);
        rd2_s = stored_word(regs_q, rf.ra2);
`endif
        rf.rd1 = rd1_s;
        rf.rd2 = rd2_s;
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile. Expected values are written
// out by hand; collision expectations depend on REGFILE_BYPASS_EN.
module tb_regfile;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    regfile_if #(.WIDTH(WIDTH)) bus ();

    regfile #(.WIDTH(WIDTH), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [WIDTH-1:0] d);
        bus.we3 = 1'b1;
        bus.wa3 = a;
        bus.wd3 = d;
        tick();
        bus.we3 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            bus.ra1 = 5'(i);
            bus.ra2 = 5'(31 - i);
            #1;
            check(tag, bus.rd1, 32'h0000_0000);
            check(tag, bus.rd2, 32'h0000_0000);
        end
    endtask

    logic [WIDTH-1:0] coll_exp;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        bus.ra1  = 5'd0;
        bus.ra2  = 5'd0;
        bus.we3  = 1'b0;
        bus.wa3  = 5'd0;
        bus.wd3  = 32'h0000_0000;

        // Initial reset: every address reads zero.
        tick();
        rst = 1'b0;
        check_all_zero("init_reset");

        // Write r5, confirm, then reset clears it and everything else.
        write_reg(5'd5, 32'hDEAD_BEEF);
        bus.ra1 = 5'd5;
        #1;
        check("r5_written", bus.rd1, 32'hDEAD_BEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("r5_reset");

        // Basic write/read on both ports; neighbour untouched.
        write_reg(5'd7, 32'h1234_5678);
        write_reg(5'd8, 32'hFFFF_FFFF);
        bus.ra1 = 5'd7;
        bus.ra2 = 5'd8;
        #1;
        check("rd1_r7", bus.rd1, 32'h1234_5678);
        check("rd2_r8", bus.rd2, 32'hFFFF_FFFF);
        bus.ra1 = 5'd6;
        #1;
        check("r6_unchanged", bus.rd1, 32'h0000_0000);

        // r0 write is discarded, never forwarded.
        bus.ra1 = 5'd0;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd0;
        bus.wd3 = 32'hA5A5_A5A5;
        #1;
        check("r0_before_edge", bus.rd1, 32'h0000_0000);
        tick();
        bus.we3 = 1'b0;
        check("r0_after_edge", bus.rd1, 32'h0000_0000);

        // Write-read collision on both ports.
        write_reg(5'd3, 32'h0000_0011);
        bus.ra1 = 5'd3;
        bus.ra2 = 5'd3;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd3;
        bus.wd3 = 32'h0000_0022;
        #1;
`ifdef REGFILE_BYPASS_EN
        coll_exp = 32'h0000_0022;
`else
        coll_exp = 32'h0000_0011;
`endif
        check("coll_rd1_pre", bus.rd1, coll_exp);
        check("coll_rd2_pre", bus.rd2, coll_exp);
        tick();
        bus.we3 = 1'b0;
        check("coll_rd1_post", bus.rd1, 32'h0000_0022);
        check("coll_rd2_post", bus.rd2, 32'h0000_0022);

        // Reset priority over a simultaneous write to r9.
        rst     = 1'b1;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd9;
        bus.wd3 = 32'h0000_0055;
        tick();
        rst     = 1'b0;
        bus.we3 = 1'b0;
        bus.ra1 = 5'd9;
        bus.ra2 = 5'd7;
        #1;
        check("rst_prio_r9", bus.rd1, 32'h0000_0000);
        check("rst_clears_r7", bus.rd2, 32'h0000_0000);

        // rst has no effect between edges and suppresses forwarding.
        write_reg(5'd10, 32'h0000_00AB);
        bus.ra1 = 5'd10;
        bus.ra2 = 5'd10;
        rst     = 1'b1;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd10;
        bus.wd3 = 32'h0000_00CC;
        #1;
        check("rst_no_async_rd1", bus.rd1, 32'h0000_00AB);
        check("rst_no_fwd_rd2", bus.rd2, 32'h0000_00AB);
        tick();
        rst     = 1'b0;
        bus.we3 = 1'b0;
        check("rst_edge_r10", bus.rd1, 32'h0000_0000);

        // Sweep: write r1..r31 with 0x100+N, hold 10 cycles, read back on both ports.
        for (int n = 1; n < 32; n++) begin
            write_reg(5'(n), 32'h0000_0100 + 32'(n));
        end
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        for (int n = 1; n < 32; n++) begin
            bus.ra1 = 5'(n);
            bus.ra2 = 5'(32 - n);
            #1;
            check("sweep_rd1", bus.rd1, 32'h0000_0100 + 32'(n));
            check("sweep_rd2", bus.rd2, 32'h0000_0100 + 32'(32 - n));
        end
        bus.ra1 = 5'd0;
        bus.ra2 = 5'd0;
        #1;
        check("sweep_r0_rd1", bus.rd1, 32'h0000_0000);
        check("sweep_r0_rd2", bus.rd2, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
